// File: rtl/mv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mv_pkg : shared sizes, FSM state type and lane-slice helper for          |
// |          the matvec sequencer.                        Rev 1.0            |
// +--------------------------------------------------------------------------+
package mv_pkg;

  localparam int N       = 8;   // lanes = rows = vector length
  localparam int DW      = 8;   // operand width
  localparam int AW      = 4;   // 2**AW must cover rows 0..N-1 plus the vector word at N
  localparam int MAC_LAT = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FETCH = 3'd2,
    S_WAIT  = 3'd3,
    S_RUN   = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  function automatic logic [DW-1:0] lane_slice(input logic [N*DW-1:0] word, input int idx);
    return word[idx*DW +: DW];
  endfunction

endpackage
`default_nettype wire

// File: rtl/matvec_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matvec_sched_if : control, memory-read and MAC-array signals of the      |
// |                   matvec sequencer.                   Rev 1.0            |
// +--------------------------------------------------------------------------+
interface matvec_sched_if;
  import mv_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_addr;
  logic [N*DW-1:0]   mem_rd_data;
  logic              mem_rd_valid;
  logic              mac_clr;
  logic [N-1:0]      mac_en;
  logic [N*DW-1:0]   mac_a;
  logic [N*DW-1:0]   mac_b;

  modport master (
    input  start, mem_rd_data, mem_rd_valid,
    output busy, done, mem_rd_en, mem_addr, mac_clr, mac_en, mac_a, mac_b
  );

  modport slave (
    output start, mem_rd_data, mem_rd_valid,
    input  busy, done, mem_rd_en, mem_addr, mac_clr, mac_en, mac_a, mac_b
  );
endinterface
`default_nettype wire

// File: rtl/mv_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mv_fetch_unit : issues N+1 in-order reads and steers the returns into    |
// |                 row/vector buffer write-enables.      Rev 1.0            |
// +--------------------------------------------------------------------------+
module mv_fetch_unit
  import mv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  issue,
  input  logic                  capture_ok,
  input  logic                  mem_rd_valid,
  output logic                  mem_rd_en,
  output logic [AW-1:0]         mem_addr,
  output logic                  a_we,
  output logic                  b_we,
  output logic [$clog2(N)-1:0]  wr_row,
  output logic                  issue_last,
  output logic                  last_ret,
  output logic                  all_ret
);

  localparam int            IW     = $clog2(N);
  localparam logic [AW-1:0] C_LAST = AW'(N);

  logic [AW-1:0] r_issue_cnt;
  logic [AW-1:0] r_ret_cnt;
  logic          r_all_ret;
  logic          w_cap;

  // Once all words are in, further valids are stray and must not touch the buffers.
  assign w_cap = capture_ok & mem_rd_valid & ~r_all_ret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_all_ret   <= 1'b0;
    end else if (clear) begin
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_all_ret   <= 1'b0;
    end else begin
      if (issue)
        r_issue_cnt <= r_issue_cnt + AW'(1);
      if (w_cap) begin
        r_ret_cnt <= r_ret_cnt + AW'(1);
        if (r_ret_cnt == C_LAST)
          r_all_ret <= 1'b1;
      end
    end
  end

  assign mem_rd_en  = issue;
  assign mem_addr   = issue ? r_issue_cnt : '0;
  assign issue_last = issue && (r_issue_cnt == C_LAST);
  assign a_we       = w_cap && (r_ret_cnt != C_LAST);
  assign b_we       = w_cap && (r_ret_cnt == C_LAST);
  assign last_ret   = b_we;
  assign wr_row     = r_ret_cnt[IW-1:0];
  assign all_ret    = r_all_ret;

endmodule
`default_nettype wire

// File: rtl/matvec_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matvec_sched : clears the MAC array, fetches A and B, streams skewed     |
// |                operand pairs per lane, drains and pulses done. Rev 1.0   |
// +--------------------------------------------------------------------------+
module matvec_sched
  import mv_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  matvec_sched_if.master bus
);

  localparam int              SW           = $clog2(2*N-1);
  localparam int              DRW          = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam int              IW           = $clog2(N);
  localparam logic [SW-1:0]   C_STEP_LAST  = SW'(2*N-2);
  localparam logic [DRW-1:0]  C_DRAIN_LAST = DRW'(MAC_LAT-1);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_clr;
  logic [SW-1:0]    r_step;
  logic [DRW-1:0]   r_drain;
  logic [N*DW-1:0]  r_abuf [N];
  logic [N*DW-1:0]  r_bbuf;

  logic             w_issue_last;
  logic             w_last_ret;
  logic             w_all_ret;
  logic             w_a_we;
  logic             w_b_we;
  logic [IW-1:0]    w_wr_row;
  logic [N-1:0]     w_en;
  logic [N*DW-1:0]  w_a;
  logic [N*DW-1:0]  w_b;

  mv_fetch_unit u_fetch (
    .clk          (clk),
    .rst          (rst),
    .clear        (r_state == S_CLR),
    .issue        (r_state == S_FETCH),
    .capture_ok   ((r_state == S_FETCH) || (r_state == S_WAIT)),
    .mem_rd_valid (bus.mem_rd_valid),
    .mem_rd_en    (bus.mem_rd_en),
    .mem_addr     (bus.mem_addr),
    .a_we         (w_a_we),
    .b_we         (w_b_we),
    .wr_row       (w_wr_row),
    .issue_last   (w_issue_last),
    .last_ret     (w_last_ret),
    .all_ret      (w_all_ret)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_clr   <= 1'b0;
      r_step  <= '0;
      r_drain <= '0;
    end else begin
      r_done <= 1'b0;
      r_clr  <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_state <= S_CLR;
          r_busy  <= 1'b1;
          r_clr   <= 1'b1;
        end
        S_CLR:   r_state <= S_FETCH;
        S_FETCH: if (w_issue_last) r_state <= S_WAIT;
        S_WAIT: if (w_all_ret || w_last_ret) begin
          r_state <= S_RUN;
          r_step  <= '0;
        end
        S_RUN: if (r_step == C_STEP_LAST) begin
          r_state <= S_DRAIN;
          r_drain <= '0;
        end else begin
          r_step <= r_step + SW'(1);
        end
        S_DRAIN: if (r_drain == C_DRAIN_LAST) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end else begin
          r_drain <= r_drain + DRW'(1);
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Buffer contents are don't-care after reset, so no reset branch here.
  always_ff @(posedge clk) begin
    if (w_a_we) r_abuf[w_wr_row] <= bus.mem_rd_data;
    if (w_b_we) r_bbuf           <= bus.mem_rd_data;
  end

  // Lane i sees element j = t-i on step t, giving the systolic diagonal wavefront.
  always_comb begin
    int t;
    t    = int'(r_step);
    w_en = '0;
    w_a  = '0;
    w_b  = '0;
    for (int i = 0; i < N; i++) begin
      if ((r_state == S_RUN) && (t >= i) && (t <= i + N - 1)) begin
        w_en[i]          = 1'b1;
        w_a[i*DW +: DW]  = lane_slice(r_abuf[i], t - i);
        w_b[i*DW +: DW]  = lane_slice(r_bbuf, t - i);
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.mac_clr = r_clr;
  assign bus.mac_en  = w_en;
  assign bus.mac_a   = w_a;
  assign bus.mac_b   = w_b;

endmodule
`default_nettype wire
